z_shiftreg_param: RTL
=====================

// Module: z_shiftreg_param
//
// PURPOSE
//   Parametrised, bidirectional WIDTH-bit x DEPTH-stage shift register / delay line.
//   Generalises the fixed 32-stage 1-bit shifter for processor pipeline timing and
//   serial I/O use. Adds the following features:
//     - per-stage valid bits, a fill counter and full/empty flags
//     - parallel load and parallel read
//     - flush, and an explicit mode field
//
// PARAMETERS
//   WIDTH      8   data bits per stage (>=1)
//   DEPTH      32  number of stages (>=2)
//   RESET_VAL  0   WIDTH-bit data value loaded into every stage on reset
//
// PORTS
//   clk        in   1              single clock, rising edge
//   reset      in   1              synchronous, active-high reset
//   ena        in   1              global enable; 0 = hold everything except reset
//   mode       in   2              00 hold, 01 shift fwd, 10 shift rev, 11 parallel load
//   flush      in   1              clear all valid bits; data unchanged
//   d          in   WIDTH          serial data in (stage 0 fwd, stage DEPTH-1 rev)
//   d_valid    in   1              valid tag accompanying d
//   pd         in   WIDTH*DEPTH    parallel load data; stage i = pd[i*WIDTH +: WIDTH]
//   q          out  WIDTH          fwd serial out = stage[DEPTH-1] data
//   q_valid    out  1              valid of stage[DEPTH-1]
//   q_rev      out  WIDTH          rev serial out = stage[0] data
//   q_rev_valid out 1              valid of stage[0]
//   pq         out  WIDTH*DEPTH    all stage data, same packing as pd
//   count      out  $clog2(DEPTH+1)  number of valid stages
//   full       out  1              count == DEPTH
//   empty      out  1              count == 0
//
// BEHAVIOUR
//   - All state is registered on rising clk. Outputs are direct register or
//     decoded-register values with zero combinational path from inputs.
//   - reset=1: every stage data <= RESET_VAL, all valid <= 0, count <= 0.
//     Thus after reset: q = q_rev = RESET_VAL, q_valid = q_rev_valid = 0,
//     empty = 1, full = 0. Reset overrides ena and everything else.
//   - Priority per cycle: reset > (ena=0: hold) > flush > mode.
//   - flush=1 & ena=1: valid[] <= 0, count <= 0, and data holds. Any mode is ignored
//     that cycle, so no shift and no load occur.
//   - mode 00: hold.
//   - mode 01 (forward shift): stage[i] <= stage[i-1] for i >= 1, and
//     stage[0] <= {d, d_valid}. The old stage[DEPTH-1] is discarded.
//   - mode 10 (reverse shift): stage[i] <= stage[i+1] for i < DEPTH-1, and
//     stage[DEPTH-1] <= {d, d_valid}. The old stage[0] is discarded.
//   - mode 11 (parallel load): stage[i].data <= pd slice i and all valid <= 1,
//     so count <= DEPTH. d and d_valid are ignored.
//   - Latency (fwd): d captured at edge N appears on q after edge N+DEPTH-1,
//     i.e. DEPTH shift cycles from presentation to q. The same latency applies to
//     rev with q_rev. Hold cycles do not advance the data.
//   - count update on shift: count_next = count + d_valid - valid(departing stage).
//     Saturation is implicit, because the sum can never exceed DEPTH or go below 0.
//     Invariant, checked every cycle: count == popcount(valid[]).
//   - Full and shift with d_valid=1: legal. The departing stage is lost;
//     count stays DEPTH if the departing stage was valid.
//   - Empty and shift with d_valid=0: count stays 0, and invalid data still moves.
//   - Direction change fwd<->rev between consecutive cycles: legal, with no bubble.
//   - Unused mode encodings: none. The 2-bit field is fully decoded.
//   - Mid-operation reset: the next edge takes the reset state regardless of
//     mode, flush or ena.
//
// STRUCTURE
//   - Shared include z_shiftreg_defs.vh holds the mode constants
//     SR_HOLD=2'b00, SR_FWD=2'b01, SR_REV=2'b10 and SR_LOAD=2'b11.
//   - Sub-module z_shift_stage: one WIDTH-bit data register plus a valid bit,
//     with a 4:1 input mux (hold / prev / next / parallel).
//     The top level is a generate loop of DEPTH stages plus the count register
//     and the full/empty decode.
//   - count is held in a register updated incrementally; it is not a
//     combinational popcount.
//
// TESTING  (WIDTH=8, DEPTH=4, RESET_VAL=8'hA5 unless noted)
//   1. Reset then idle. Expect:
//      - q = q_rev = 8'hA5, pq = 32'hA5A5A5A5
//      - q_valid = 0, count = 0, empty = 1, full = 0
//   2. Fwd shift d = 11,22,33,44 with d_valid=1 (4 cycles). Expect:
//      - q = 8'h11 and q_valid = 1 after the 4th edge
//      - count = 4, full = 1, pq = 32'h11223344
//      Then shift in 55 valid: q = 22, count stays 4.
//   3. Parallel load pd = 32'hDEADBEEF, then 2 rev shifts with d_valid=0. Expect:
//      - after load: q_rev = EF
//      - after the 2 rev shifts: q_rev = AD, count = 2, valid[3:2] = 0
//   4. Full register, then assert flush together with mode=01. Expect:
//      - count = 0, empty = 1
//      - pq unchanged, i.e. no shift occurred
//   5. ena=0 while mode=11 and flush=1. Expect:
//      - no state change for 3 cycles
//      - raising reset during ena=0 still yields the reset state
//   6. Random mode, d, d_valid and flush for 10k cycles, with DEPTH=32 and
//      WIDTH=1 as well as the default. Check each cycle against a reference model:
//      - the count == popcount(valid) invariant
//      - full/empty consistency
//      - q sequence versus a golden queue model

Source files
------------

// File: rtl/z_shiftreg_param_pkg.sv
// Shared mode encoding and small helpers for the z_shiftreg_param shift register.
// The mode field is fully decoded: every 2-bit value has a defined action.
package z_shiftreg_param_pkg;

   localparam logic [1:0] SR_HOLD = 2'b00;
   localparam logic [1:0] SR_FWD  = 2'b01;
   localparam logic [1:0] SR_REV  = 2'b10;
   localparam logic [1:0] SR_LOAD = 2'b11;

   typedef enum logic [1:0] {
      MODE_HOLD = SR_HOLD,
      MODE_FWD  = SR_FWD,
      MODE_REV  = SR_REV,
      MODE_LOAD = SR_LOAD
   } sr_mode_e;

   function automatic sr_mode_e decode_mode(input logic [1:0] raw);
      return sr_mode_e'(raw);
   endfunction

endpackage

// File: rtl/z_shift_stage.sv
// One stage of the shift register: WIDTH-bit data plus a valid tag, selected
// from hold / previous stage / next stage / parallel input.
module z_shift_stage
   import z_shiftreg_param_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ena,
   input  logic             flush,
   input  sr_mode_e         mode,
   input  logic [WIDTH-1:0] prev_data,
   input  logic             prev_valid,
   input  logic [WIDTH-1:0] next_data,
   input  logic             next_valid,
   input  logic [WIDTH-1:0] par_data,
   output logic [WIDTH-1:0] data,
   output logic             valid
);

   logic [WIDTH-1:0] data_reg, data_next;
   logic             valid_reg, valid_next;

   always_comb begin
      data_next  = data_reg;
      valid_next = valid_reg;
      if (ena) begin
         // Flush only drops the tags; the data bits stay where they are.
         if (flush) begin
            valid_next = 1'b0;
         end else begin
            unique case (mode)
               MODE_HOLD: ;
               MODE_FWD: begin
                  data_next  = prev_data;
                  valid_next = prev_valid;
               end
               MODE_REV: begin
                  data_next  = next_data;
                  valid_next = next_valid;
               end
               MODE_LOAD: begin
                  data_next  = par_data;
                  valid_next = 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_reg  <= RESET_VAL;
         valid_reg <= 1'b0;
      end else begin
         data_reg  <= data_next;
         valid_reg <= valid_next;
      end
   end

   assign data  = data_reg;
   assign valid = valid_reg;

endmodule

// File: rtl/z_shiftreg_param.sv
// Bidirectional WIDTH x DEPTH shift register / delay line with per-stage valid
// tags, parallel load/read, flush and an incrementally maintained fill count.
module z_shiftreg_param
   import z_shiftreg_param_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter int               DEPTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int              CW        = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ena,
   input  logic [1:0]             mode,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       d,
   input  logic                   d_valid,
   input  logic [WIDTH*DEPTH-1:0] pd,
   output logic [WIDTH-1:0]       q,
   output logic                   q_valid,
   output logic [WIDTH-1:0]       q_rev,
   output logic                   q_rev_valid,
   output logic [WIDTH*DEPTH-1:0] pq,
   output logic [CW-1:0]          count,
   output logic                   full,
   output logic                   empty
);

   sr_mode_e         mode_dec;
   logic [WIDTH-1:0] stage_data  [DEPTH];
   logic [DEPTH-1:0] stage_valid;
   logic [WIDTH-1:0] prev_data   [DEPTH];
   logic [DEPTH-1:0] prev_valid;
   logic [WIDTH-1:0] next_data   [DEPTH];
   logic [DEPTH-1:0] next_valid;

   assign mode_dec = decode_mode(mode);

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
         // Serial input enters stage 0 going forward and stage DEPTH-1 going reverse.
         if (gi == 0) begin : g_first
            assign prev_data[gi]  = d;
            assign prev_valid[gi] = d_valid;
         end else begin : g_mid_prev
            assign prev_data[gi]  = stage_data[gi-1];
            assign prev_valid[gi] = stage_valid[gi-1];
         end

         if (gi == DEPTH - 1) begin : g_last
            assign next_data[gi]  = d;
            assign next_valid[gi] = d_valid;
         end else begin : g_mid_next
            assign next_data[gi]  = stage_data[gi+1];
            assign next_valid[gi] = stage_valid[gi+1];
         end

         z_shift_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
         ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .ena        (ena),
            .flush      (flush),
            .mode       (mode_dec),
            .prev_data  (prev_data[gi]),
            .prev_valid (prev_valid[gi]),
            .next_data  (next_data[gi]),
            .next_valid (next_valid[gi]),
            .par_data   (pd[gi*WIDTH +: WIDTH]),
            .data       (stage_data[gi]),
            .valid      (stage_valid[gi])
         );

         assign pq[gi*WIDTH +: WIDTH] = stage_data[gi];
      end
   endgenerate

   logic [CW-1:0] count_reg, count_next;

   // Modular arithmetic is safe here: the true result always lies in 0..DEPTH.
   always_comb begin
      count_next = count_reg;
      if (ena) begin
         if (flush) begin
            count_next = '0;
         end else begin
            unique case (mode_dec)
               MODE_HOLD: ;
               MODE_FWD:  count_next = count_reg + CW'(d_valid) - CW'(stage_valid[DEPTH-1]);
               MODE_REV:  count_next = count_reg + CW'(d_valid) - CW'(stage_valid[0]);
               MODE_LOAD: count_next = CW'(DEPTH);
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   assign q           = stage_data[DEPTH-1];
   assign q_valid     = stage_valid[DEPTH-1];
   assign q_rev       = stage_data[0];
   assign q_rev_valid = stage_valid[0];
   assign count       = count_reg;
   assign full        = (count_reg == CW'(DEPTH));
   assign empty       = (count_reg == '0);

endmodule
